// File: rtl/vm_order_entry_if.sv
// vm_order_entry_if: request, result and status bundle
// between the order-entry front end and its environment.
interface vm_order_entry_if;
   logic       coin_valid;
   logic [1:0] coin_value;
   logic       sel_valid;
   logic [1:0] sel_tag;
   logic [2:0] sel_count;
   logic       confirm;
   logic       cancel;
   logic [1:0] Tag;
   logic [2:0] count;
   logic [3:0] money;
   logic       possibility;
   logic [3:0] remainingMoney;
   logic       busy;
   logic       coin_reject;
   logic       sel_err;
   logic       vend_ok;
   logic       vend_fail;
   logic       refund_valid;
   logic [3:0] refund_amount;

   modport master (
      output coin_valid, coin_value, sel_valid, sel_tag,
      output sel_count, confirm, cancel,
      output possibility, remainingMoney,
      input  Tag, count, money, busy, coin_reject, sel_err,
      input  vend_ok, vend_fail, refund_valid, refund_amount
   );

   modport slave (
      input  coin_valid, coin_value, sel_valid, sel_tag,
      input  sel_count, confirm, cancel,
      input  possibility, remainingMoney,
      output Tag, count, money, busy, coin_reject, sel_err,
      output vend_ok, vend_fail, refund_valid, refund_amount
   );
endinterface

// File: rtl/vm_order_entry.sv
// vm_order_entry: coin/selection collector feeding the
// combinational vending core, with result and refund handling.
module vm_order_entry #(
   parameter int TIMEOUT = 255
) (
   input logic              clk,
   input logic              rst,
   vm_order_entry_if.slave  bus
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_EVAL    = 2'd2;
   localparam logic [1:0] S_REFUND  = 2'd3;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0] r_state;
   logic [3:0] r_credit;
   logic [1:0] r_tag;
   logic [2:0] r_count;
   logic [7:0] r_tmo;
   logic [1:0] r_tag_o;
   logic [2:0] r_count_o;
   logic [3:0] r_money_o;
   logic       r_busy;
   logic       r_coin_rej;
   logic       r_sel_err;
   logic       r_vend_ok;
   logic       r_vend_fail;
   logic       r_rf_vld;
   logic [3:0] r_rf_amt;

   logic [1:0] w_state;
   logic [3:0] w_credit;
   logic [1:0] w_tag;
   logic [2:0] w_count;
   logic [7:0] w_tmo;
   logic [1:0] w_tag_o;
   logic [2:0] w_count_o;
   logic [3:0] w_money_o;
   logic       w_coin_rej;
   logic       w_sel_err;
   logic       w_vend_ok;
   logic       w_vend_fail;
   logic       w_rf_vld;
   logic [3:0] w_rf_amt;

   logic [2:0] w_coin_amt;
   logic [4:0] w_sum;
   logic       w_coin_fits;
   logic       w_any;
   logic [2:0] w_cnt_eff;
   logic [1:0] w_tag_eff;

   // Decode coin value and check it against the 4-bit credit limit
   always_comb begin
      w_coin_amt = 3'd0;
      unique case (bus.coin_value)
         2'b00:   w_coin_amt = 3'd1;
         2'b01:   w_coin_amt = 3'd2;
         2'b10:   w_coin_amt = 3'd5;
         default: w_coin_amt = 3'd0;
      endcase
   end

   assign w_sum = {1'b0, r_credit} + {2'b00, w_coin_amt};
   assign w_coin_fits = (bus.coin_value != 2'b11) && !w_sum[4];
   assign w_any = bus.coin_valid | bus.sel_valid
                | bus.confirm | bus.cancel;
   // A selection arriving with confirm is used by that confirm
   assign w_cnt_eff = bus.sel_valid ? bus.sel_count : r_count;
   assign w_tag_eff = bus.sel_valid ? bus.sel_tag : r_tag;

   // Next-state and next-output computation for the order FSM
   always_comb begin
      w_state     = r_state;
      w_credit    = r_credit;
      w_tag       = r_tag;
      w_count     = r_count;
      w_tmo       = r_tmo;
      w_tag_o     = r_tag_o;
      w_count_o   = 3'd0;
      w_money_o   = 4'd0;
      w_coin_rej  = 1'b0;
      w_sel_err   = 1'b0;
      w_vend_ok   = 1'b0;
      w_vend_fail = 1'b0;
      w_rf_vld    = 1'b0;
      w_rf_amt    = 4'd0;
      unique case (r_state)
         S_IDLE: begin
            if (bus.sel_valid) begin
               w_tag   = bus.sel_tag;
               w_count = bus.sel_count;
            end
            if (bus.coin_valid) begin
               if (w_coin_fits) begin
                  w_credit = w_sum[3:0];
                  w_state  = S_COLLECT;
                  w_tmo    = 8'd0;
               end else begin
                  w_coin_rej = 1'b1;
               end
            end
         end
         S_COLLECT: begin
            if (bus.sel_valid) begin
               w_tag   = bus.sel_tag;
               w_count = bus.sel_count;
            end
            if (bus.cancel) begin
               w_state    = S_REFUND;
               w_rf_vld   = 1'b1;
               w_rf_amt   = r_credit;
               w_coin_rej = bus.coin_valid;
               w_tmo      = 8'd0;
            end else if (bus.confirm) begin
               w_coin_rej = bus.coin_valid;
               w_tmo      = 8'd0;
               if (w_cnt_eff != 3'd0) begin
                  w_state   = S_EVAL;
                  w_count_o = w_cnt_eff;
                  w_money_o = r_credit;
                  w_tag_o   = w_tag_eff;
               end else begin
                  w_sel_err = 1'b1;
               end
            end else begin
               if (bus.coin_valid) begin
                  if (w_coin_fits) begin
                     w_credit = w_sum[3:0];
                  end else begin
                     w_coin_rej = 1'b1;
                  end
               end
               if (w_any) begin
                  w_tmo = 8'd0;
               end else if (r_tmo == TMO_LAST) begin
                  w_state  = S_REFUND;
                  w_rf_vld = 1'b1;
                  w_rf_amt = r_credit;
                  w_tmo    = 8'd0;
               end else begin
                  w_tmo = r_tmo + 8'd1;
               end
            end
         end
         S_EVAL: begin
            w_state     = S_REFUND;
            w_coin_rej  = bus.coin_valid;
            w_rf_vld    = 1'b1;
            w_vend_ok   = bus.possibility;
            w_vend_fail = !bus.possibility;
            w_rf_amt    = bus.possibility ? bus.remainingMoney
                                          : r_credit;
         end
         S_REFUND: begin
            w_state    = S_IDLE;
            w_credit   = 4'd0;
            w_tag      = 2'd0;
            w_count    = 3'd0;
            w_tmo      = 8'd0;
            w_coin_rej = bus.coin_valid;
         end
         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // Register state, latched order and all outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_credit    <= 4'd0;
         r_tag       <= 2'd0;
         r_count     <= 3'd0;
         r_tmo       <= 8'd0;
         r_tag_o     <= 2'd0;
         r_count_o   <= 3'd0;
         r_money_o   <= 4'd0;
         r_busy      <= 1'b0;
         r_coin_rej  <= 1'b0;
         r_sel_err   <= 1'b0;
         r_vend_ok   <= 1'b0;
         r_vend_fail <= 1'b0;
         r_rf_vld    <= 1'b0;
         r_rf_amt    <= 4'd0;
      end else begin
         r_state     <= w_state;
         r_credit    <= w_credit;
         r_tag       <= w_tag;
         r_count     <= w_count;
         r_tmo       <= w_tmo;
         r_tag_o     <= w_tag_o;
         r_count_o   <= w_count_o;
         r_money_o   <= w_money_o;
         r_busy      <= (w_state == S_EVAL)
                     || (w_state == S_REFUND);
         r_coin_rej  <= w_coin_rej;
         r_sel_err   <= w_sel_err;
         r_vend_ok   <= w_vend_ok;
         r_vend_fail <= w_vend_fail;
         r_rf_vld    <= w_rf_vld;
         r_rf_amt    <= w_rf_amt;
      end
   end

   assign bus.Tag           = r_tag_o;
   assign bus.count         = r_count_o;
   assign bus.money         = r_money_o;
   assign bus.busy          = r_busy;
   assign bus.coin_reject   = r_coin_rej;
   assign bus.sel_err       = r_sel_err;
   assign bus.vend_ok       = r_vend_ok;
   assign bus.vend_fail     = r_vend_fail;
   assign bus.refund_valid  = r_rf_vld;
   assign bus.refund_amount = r_rf_amt;

endmodule

// File: doc/vm_order_entry.md
Name: vm_order_entry

Overview:
Sequential front end that feeds the combinational vending core.
- Accumulates inserted coins into a 4-bit credit and latches the product tag and quantity selection.
- On confirm, presents one stable Tag/count/money request to the core and samples the core's possibility/remainingMoney response.
- Reports success or failure, then emits a single refund of change or of the full credit.

Parameters:
TIMEOUT, 255, idle cycles in COLLECT with no coin/select/confirm/cancel before an automatic refund (1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
coin_valid  input  1  one-cycle coin insertion strobe
coin_value  input  2  00=1, 01=2, 10=5 units; 11=invalid coin
sel_valid  input  1  selection strobe
sel_tag  input  2  product tag to latch
sel_count  input  3  quantity to latch
confirm  input  1  purchase request strobe
cancel  input  1  abort strobe
Tag  output  2  tag to vending core
count  output  3  quantity to vending core
money  output  4  credit to vending core
possibility  input  1  core result: purchase possible
remainingMoney  input  4  core result: change
busy  output  1  high in EVAL and REFUND
coin_reject  output  1  one-cycle pulse: coin refused
sel_err  output  1  one-cycle pulse: confirm with no selection or count=0
vend_ok  output  1  one-cycle pulse: purchase succeeded
vend_fail  output  1  one-cycle pulse: purchase refused by core
refund_valid  output  1  one-cycle refund strobe
refund_amount  output  4  refund value, valid with refund_valid

Behaviour:
- Reset: state=IDLE; credit, latched tag/count and the timeout counter = 0; all outputs 0.
  - Reset mid-operation discards credit.
  - No refund is emitted after reset.
- States: IDLE, COLLECT, EVAL, REFUND.
- IDLE:
  - An accepted coin loads the credit and moves to COLLECT.
  - sel_valid latches tag/count; state is unchanged.
  - confirm and cancel are ignored.
- COLLECT:
  - A coin is accepted if credit + value <= 15: credit is updated.
  - A coin is rejected (coin_reject pulse, credit unchanged) if the sum exceeds 15 or coin_value=11.
  - sel_valid overwrites the latched selection.
  - confirm with a latched count != 0 goes to EVAL.
  - confirm with no selection or count=0: sel_err pulse, stay in COLLECT.
  - cancel goes to REFUND with amount = credit.
  - Timeout counter resets on any coin/select/confirm/cancel strobe; otherwise it increments. At TIMEOUT, go to REFUND with amount = credit.
- Priority within one cycle: cancel > confirm > sel_valid > coin.
  - A coin arriving in the same cycle as cancel or confirm is rejected with coin_reject.
  - sel_valid in the same cycle as confirm is applied first, so confirm uses the new selection.
- Core interface:
  - Tag, count and money are registered.
  - Outside EVAL, count=0 and money=0 so the core never consumes stock. Tag holds its last value.
  - EVAL lasts exactly one cycle: count/money carry the latched count and credit; Tag carries the latched tag.
  - possibility/remainingMoney are sampled at the end of EVAL.
- Result handling:
  - possibility=1: vend_ok pulse; refund amount = remainingMoney.
  - possibility=0: vend_fail pulse; refund amount = credit.
  - The pulse asserts in the first REFUND cycle.
- REFUND lasts one cycle:
  - refund_valid=1 and refund_amount as above; a zero amount still pulses refund_valid.
  - Credit, latched selection and the timeout counter are then cleared; return to IDLE.
  - Coins in EVAL/REFUND are rejected. All other strobes are ignored.
- Latency:
  - Confirm sampled at edge N: EVAL in cycle N+1; REFUND/vend_ok/vend_fail in cycle N+2; IDLE at N+3.
  - Cancel sampled at edge N: refund_valid in cycle N+1.
- Arithmetic: 4-bit unsigned credit; overflow is prevented by the reject rule, so no wrap-around.

Test Plan:
- Coins 5, 5, 2 (credit 12), select tag=1 count=2, confirm; core returns possibility=1, remainingMoney=4 -> count=2, money=12, Tag=1 for one cycle; vend_ok and refund_valid with refund_amount=4 two cycles after confirm.
- Credit 3, select count=5, confirm; core returns possibility=0 -> vend_fail; refund_amount=3; count back to 0.
- Credit 14, insert coin 2 -> coin_reject, credit stays 14; insert coin 1 -> credit 15.
- Credit 7, confirm and cancel in the same cycle -> no EVAL cycle; refund_valid with 7 next cycle; no vend_ok/vend_fail.
- Credit 6 with no selection, confirm -> sel_err pulse; stays in COLLECT; then TIMEOUT=4 idle cycles -> refund_valid with 6.
- Credit 9, assert rst during EVAL -> next cycle all outputs 0 and state IDLE; no refund_valid.
